// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: decodes the M-stage access, runs one req/ack
// transaction per instruction, extends load data and flags misalignment/timeouts.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] InstrM,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] ReadDataM,
  output logic        stall_m,
  output logic        addr_err,
  output logic        bus_err
);
  // state | meaning
  // IDLE  | waiting for an M-stage access; stalls while an aligned one is pending
  // REQ   | request on the bus, waiting for ack or timeout
  // DONE  | access finished, pipeline advances on this edge
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [5:0]  opcode;
  logic        op_valid, access, misaligned, start, last_wait;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [5:0]  op_q;
  logic [1:0]  off_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign opcode = InstrM[31:26];

  always_comb begin
    case (opcode)
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  end

  // opcode[1:0] encodes size (00 byte, 01 half, 11 word), opcode[2] unsigned, opcode[3] store
  assign access     = (MemtoRegM | MemWriteM) & op_valid;
  assign misaligned = ((opcode[1:0] == 2'b01) & ALUOutM[0]) |
                      ((opcode[1:0] == 2'b11) & (ALUOutM[1:0] != 2'b00));
  assign start      = access & ~misaligned;
  assign last_wait  = (cnt == CNT_LAST);

  always_comb begin
    case (opcode[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ALUOutM[1:0];
        wdata_c = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_c    = ALUOutM[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = WriteDataM;
      end
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q[1:0])
      2'b00:   load_ext = op_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = op_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = REQ;
      REQ:     if (mem_ack || last_wait) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Gated by rst_n so a reset mid-access releases the pipeline immediately
  always_comb begin
    stall_m  = 1'b0;
    addr_err = 1'b0;
    if (rst_n) begin
      stall_m  = ((state == IDLE) & start) | (state == REQ);
      addr_err = (state == IDLE) & access & misaligned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      op_q      <= '0;
      off_q     <= '0;
      ReadDataM <= '0;
      bus_err   <= 1'b0;
    end else begin
      cnt     <= ((state == REQ) && (next_state == REQ)) ? cnt + 1'b1 : '0;
      bus_err <= (state == REQ) & ~mem_ack & last_wait;
      if ((state == IDLE) && start) begin
        mem_req   <= 1'b1;
        mem_we    <= opcode[3];
        mem_addr  <= {ALUOutM[31:2], 2'b00};
        mem_be    <= be_c;
        mem_wdata <= wdata_c;
        op_q      <= opcode;
        off_q     <= ALUOutM[1:0];
      end
      if (state == REQ) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (!op_q[3]) ReadDataM <= load_ext;
        end else if (last_wait) begin
          mem_req   <= 1'b0;
          ReadDataM <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit with a scoreboard queue of expected
// transaction results, plus hand-written reset and stray-ack sequences.
module tb_mem_access_unit;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemWriteM = 1'b0, MemtoRegM = 1'b0;
  logic [31:0] ALUOutM = '0, WriteDataM = '0, InstrM = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, mem_we, stall_m, addr_err, bus_err;
  logic [31:0] mem_addr, mem_wdata, ReadDataM;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .InstrM(InstrM),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .ReadDataM(ReadDataM), .stall_m(stall_m), .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        mr, mw;
    logic [31:0] addr, wd, rdata;
    int          waits;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr, mwdata, rd;
    int          stall, req, aerr, berr;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_access(input vec_t v);
    int st = 0, rq = 0, ae = 0, be_n = 0;
    logic done = 1'b0;
    logic        c_we = 1'b0;
    logic [3:0]  c_be = '0;
    logic [31:0] c_addr = '0, c_wdata = '0, rd = '0;
    vec_t e;
    InstrM     = {v.op, 26'h0};
    MemtoRegM  = v.mr;
    MemWriteM  = v.mw;
    ALUOutM    = v.addr;
    WriteDataM = v.wd;
    sb.push_back(v);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
      if (stall_m)  st++;
      if (addr_err) ae++;
      if (bus_err)  be_n++;
      if (mem_req) begin
        rq++;
        if (rq == 1) begin
          c_we = mem_we; c_be = mem_be; c_addr = mem_addr; c_wdata = mem_wdata;
        end
        if (rq == v.waits + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      if (!stall_m) begin
        done = 1'b1;
        rd   = ReadDataM;
        break;
      end
    end
    @(posedge clk);
    #1;
    mem_ack = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0; InstrM = '0;
    e = sb.pop_front();
    check({e.name, "_completes"}, {31'b0, done}, 32'd1);
    check({e.name, "_stall"}, st, e.stall);
    check({e.name, "_req"}, rq, e.req);
    check({e.name, "_addr_err"}, ae, e.aerr);
    check({e.name, "_bus_err"}, be_n, e.berr);
    check({e.name, "_rdata"}, rd, e.rd);
    if (e.req > 0) begin
      check({e.name, "_we"}, {31'b0, c_we}, {31'b0, e.we});
      check({e.name, "_be"}, {28'b0, c_be}, {28'b0, e.be});
      check({e.name, "_addr"}, c_addr, e.maddr);
      if (e.we) check({e.name, "_wdata"}, c_wdata, e.mwdata);
    end
  endtask

  initial begin
    vec_t post;
    //          name        op     mr mw addr          wd            rdata         w   we be       maddr         mwdata        rd            st rq ae be
    vecs.push_back('{"lw_100",   6'h23, 1, 0, 32'h100, 32'h0,          32'hDEADBEEF, 0,  0, 4'b1111, 32'h100, 32'h0,          32'hDEADBEEF, 2, 1, 0, 0});
    vecs.push_back('{"lb_103",   6'h20, 1, 0, 32'h103, 32'h0,          32'h80FF1234, 0,  0, 4'b1000, 32'h100, 32'h0,          32'hFFFFFF80, 2, 1, 0, 0});
    vecs.push_back('{"lbu_103",  6'h24, 1, 0, 32'h103, 32'h0,          32'h80FF1234, 0,  0, 4'b1000, 32'h100, 32'h0,          32'h00000080, 2, 1, 0, 0});
    vecs.push_back('{"lhu_102",  6'h25, 1, 0, 32'h102, 32'h0,          32'h80FF1234, 0,  0, 4'b1100, 32'h100, 32'h0,          32'h000080FF, 2, 1, 0, 0});
    vecs.push_back('{"lh_102",   6'h21, 1, 0, 32'h102, 32'h0,          32'h80FF1234, 1,  0, 4'b1100, 32'h100, 32'h0,          32'hFFFF80FF, 3, 2, 0, 0});
    vecs.push_back('{"sh_202",   6'h29, 0, 1, 32'h202, 32'h0000ABCD,   32'h0,        3,  1, 4'b1100, 32'h200, 32'hABCDABCD,   32'hFFFF80FF, 5, 4, 0, 0});
    vecs.push_back('{"sb_201",   6'h28, 0, 1, 32'h201, 32'h123456A5,   32'h0,        0,  1, 4'b0010, 32'h200, 32'hA5A5A5A5,   32'hFFFF80FF, 2, 1, 0, 0});
    vecs.push_back('{"sw_300",   6'h2B, 0, 1, 32'h300, 32'hCAFEF00D,   32'h0,        2,  1, 4'b1111, 32'h300, 32'hCAFEF00D,   32'hFFFF80FF, 4, 3, 0, 0});
    vecs.push_back('{"lw_101",   6'h23, 1, 0, 32'h101, 32'h0,          32'h0,        0,  0, 4'b0,    32'h0,   32'h0,          32'hFFFF80FF, 0, 0, 1, 0});
    vecs.push_back('{"lh_103",   6'h21, 1, 0, 32'h103, 32'h0,          32'h0,        0,  0, 4'b0,    32'h0,   32'h0,          32'hFFFF80FF, 0, 0, 1, 0});
    vecs.push_back('{"lb_102",   6'h20, 1, 0, 32'h102, 32'h0,          32'h00FE0000, 0,  0, 4'b0100, 32'h100, 32'h0,          32'hFFFFFFFE, 2, 1, 0, 0});
    vecs.push_back('{"lw_tmo",   6'h23, 1, 0, 32'h104, 32'h0,          32'h11111111, 99, 0, 4'b1111, 32'h104, 32'h0,          32'h00000000, 5, 4, 0, 1});
    vecs.push_back('{"bad_op",   6'h0F, 1, 0, 32'h100, 32'h0,          32'h0,        0,  0, 4'b0,    32'h0,   32'h0,          32'h00000000, 0, 0, 0, 0});
    vecs.push_back('{"lhu_100",  6'h25, 1, 0, 32'h100, 32'h0,          32'h12348001, 0,  0, 4'b0011, 32'h100, 32'h0,          32'h00008001, 2, 1, 0, 0});
    vecs.push_back('{"no_flags", 6'h23, 0, 0, 32'h100, 32'h0,          32'h0,        0,  0, 4'b0,    32'h0,   32'h0,          32'h00008001, 0, 0, 0, 0});

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_stall", {31'b0, stall_m}, 32'd0);
    check("rst_rdata", ReadDataM, 32'd0);
    check("rst_be", {28'b0, mem_be}, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_access(vecs[i]);

    // stray ack with no access in flight must be ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check("stray_ack_req", {31'b0, mem_req}, 32'd0);
    check("stray_ack_rdata", ReadDataM, 32'h00008001);
    mem_ack = 1'b0;
    @(posedge clk); #1;

    // reset asserted in the middle of a REQ phase
    InstrM = {6'h23, 26'h0}; MemtoRegM = 1'b1; ALUOutM = 32'h100;
    for (int c = 0; c < 10 && !mem_req; c++) @(negedge clk);
    check("midreq_reached", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreq_rst_req", {31'b0, mem_req}, 32'd0);
    check("midreq_rst_stall", {31'b0, stall_m}, 32'd0);
    check("midreq_rst_rdata", ReadDataM, 32'd0);
    MemtoRegM = 1'b0; InstrM = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req", {31'b0, mem_req}, 32'd0);
    check("post_rst_stall", {31'b0, stall_m}, 32'd0);
    @(posedge clk); #1;

    post = vecs[0];
    post.name = "lw_after_rst";
    run_access(post);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded limit");
    $fatal(1, "bench watchdog");
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit placed directly downstream of the EX/MEM pipeline register. It decodes the M-stage instruction into byte/halfword/word accesses, drives a request/acknowledge data-memory port with correct byte enables, and sign- or zero-extends load data. It stalls the pipeline until the access completes and reports misaligned accesses and memory timeouts to the hazard/exception logic.

## Interface
- TIMEOUT_CYCLES, 16: max REQ cycles without ack before a bus error.
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- MemWriteM  in  1  store in M stage
- MemtoRegM  in  1  load in M stage
- ALUOutM  in  32  effective byte address
- WriteDataM  in  32  store data (low bits used for sb/sh)
- InstrM  in  32  M-stage instruction; opcode = InstrM[31:26]
- mem_ack  in  1  memory completion, sampled only in REQ
- mem_rdata  in  32  read word, valid with mem_ack
- mem_req  out  1  access request (registered)
- mem_we  out  1  1 = write
- mem_addr  out  32  {ALUOutM[31:2], 2'b00}
- mem_be  out  4  byte enables, bit n = bits 8n+7:8n
- mem_wdata  out  32  lane-replicated store data
- ReadDataM  out  32  extended load result, to MEM/WB register
- stall_m  out  1  hold M stage and all upstream stages
- addr_err  out  1  one-cycle misalignment pulse
- bus_err  out  1  one-cycle timeout pulse

## Operation
- Opcodes: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B. Access only when (MemtoRegM or MemWriteM) and opcode is one of these; other opcodes with the flags set are ignored.
- Little-endian lanes: byte at offset k = addr[1:0] sits in bits 8k+7:8k.
- mem_be: byte 4'b0001<<addr[1:0]; half addr[1] ? 4'b1100 : 4'b0011; word 4'b1111; loads drive the same mask.
- mem_wdata: sb {4{WriteDataM[7:0]}}, sh {2{WriteDataM[15:0]}}, sw WriteDataM.
- Load extract: selected byte/half from mem_rdata; lb/lh sign-extend, lbu/lhu zero-extend, lw whole word. Captured into ReadDataM on ack; ReadDataM otherwise holds.
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0. No request; addr_err pulses for the cycle the instruction is presented; stall_m stays 0; ReadDataM unchanged.
- FSM states IDLE, REQ, DONE:
  - IDLE: stall_m = 1 if aligned access pending; → REQ, latching addr/we/be/wdata/opcode.
  - REQ: mem_req = 1, outputs stable, stall_m = 1, wait counter increments. ack → DONE (load data captured). Counter reaching TIMEOUT_CYCLES without ack → DONE, bus_err pulse, ReadDataM = 0.
  - DONE: mem_req = 0, stall_m = 0 so the pipeline advances at this edge; → IDLE unconditionally.
- Counter is 0 in IDLE and DONE; width clog2(TIMEOUT_CYCLES+1).

## Timing
- Reset (async, rst_n low): state IDLE, mem_req/mem_we/mem_be/mem_addr/mem_wdata/ReadDataM/addr_err/bus_err/counter = 0; mem_req drops immediately, aborting any access. First access begins from IDLE after release.
- stall_m is combinational from state and M-stage inputs; all memory outputs are registered.
- Zero-wait memory (ack in first REQ cycle): 2 stall cycles (IDLE, REQ) + DONE; next instruction appears in IDLE.
- N wait cycles add N stall cycles. mem_req falls the cycle after ack; ack outside REQ is ignored.
- Timeout: bus_err high during the DONE cycle; total REQ cycles = TIMEOUT_CYCLES.
- Back-to-back accesses: each pays IDLE→REQ→DONE; no overlap.
- ack arriving on the timeout cycle: ack wins, no bus_err.

## Test plan
- Reset: drive rst_n low mid-REQ -> mem_req, stall_m, ReadDataM all 0 same cycle; FSM in IDLE after release.
- lw addr 0x100, ack in 1st REQ cycle, rdata 0xDEADBEEF -> mem_addr 0x100, be 4'b1111, stall_m high 2 cycles, ReadDataM 0xDEADBEEF in DONE.
- lb addr 0x103, rdata 0x80FF1234 -> be 4'b1000, ReadDataM 0xFFFFFF80; lbu same -> 0x00000080; lhu addr 0x102 -> 0x000080FF.
- sh addr 0x202, WriteDataM 0x0000ABCD, ack after 3 waits -> mem_we 1, be 4'b1100, wdata 0xABCDABCD, stall_m high 5 cycles.
- lw addr 0x101 -> addr_err one-cycle pulse, mem_req never high, stall_m 0.
- TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles, bus_err pulse, ReadDataM 0, pipeline resumes.
